// File: rtl/ship_placement_if.sv
// ship_placement_if: cursor/command inputs and board read/status outputs of the placement controller
interface ship_placement_if;
  logic [3:0] cursor_x;
  logic [3:0] cursor_y;
  logic       rotate;
  logic       place;
  logic       clear;
  logic [6:0] rd_addr;
  logic       rd_ship;
  logic       rd_preview;
  logic       busy;
  logic       place_ok;
  logic       place_err;
  logic [3:0] ship_idx;
  logic [2:0] ship_len;
  logic       orient;
  logic       all_placed;
  modport master (
    output cursor_x, cursor_y, rotate, place, clear, rd_addr,
    input  rd_ship, rd_preview, busy, place_ok, place_err, ship_idx, ship_len, orient, all_placed
  );
  modport slave (
    input  cursor_x, cursor_y, rotate, place, clear, rd_addr,
    output rd_ship, rd_preview, busy, place_ok, place_err, ship_idx, ship_len, orient, all_placed
  );
endinterface

// File: rtl/ship_placement_ctrl.sv
// ship_placement_ctrl: bounds/overlap-checked placement of a 10-ship fleet into a 10x10 occupancy store
module ship_placement_ctrl (
  input logic clk,
  input logic rst,
  ship_placement_if.slave sp
);
  typedef enum logic [1:0] {IDLE, CHECK, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [99:0] store;
  logic [3:0] lx, ly, idx, cx, cy, px, py, a0, c0;
  logic lo, ori, po, in_bounds, last, occ, ok, err, hit;
  logic [1:0] k;
  logic [2:0] len;
  logic [4:0] x_end, y_end;
  logic [6:0] caddr, rrow, rcol, along, across;
  assign len = idx == 4'd0 ? 3'd4 : idx < 4'd3 ? 3'd3 : idx < 4'd6 ? 3'd2 : idx < 4'd10 ? 3'd1 : 3'd0;
  assign x_end = {1'b0, sp.cursor_x} + (ori ? 5'd0 : {2'b0, len} - 5'd1);
  assign y_end = {1'b0, sp.cursor_y} + (ori ? {2'b0, len} - 5'd1 : 5'd0);
  assign in_bounds = x_end <= 5'd9 && y_end <= 5'd9;
  assign last = {1'b0, k} == len - 3'd1;
  assign cx = lx + (lo ? 4'd0 : {2'b0, k});
  assign cy = ly + (lo ? {2'b0, k} : 4'd0);
  assign caddr = 7'd10 * {3'b0, cy} + {3'b0, cx};
  assign occ = store[caddr];
  // candidate footprint test for the draw path: cursor while idle, latched ship while busy
  assign px = state == IDLE ? sp.cursor_x : lx;
  assign py = state == IDLE ? sp.cursor_y : ly;
  assign po = state == IDLE ? ori : lo;
  assign rrow = sp.rd_addr / 7'd10;
  assign rcol = sp.rd_addr % 7'd10;
  assign along = po ? rrow : rcol;
  assign across = po ? rcol : rrow;
  assign a0 = po ? py : px;
  assign c0 = po ? px : py;
  assign hit = across == {3'b0, c0} && along >= {3'b0, a0} && along < {3'b0, a0} + {4'b0, len};
  assign sp.ship_idx = idx;
  assign sp.ship_len = len;
  assign sp.orient = ori;
  assign sp.place_ok = ok;
  assign sp.place_err = err;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // next state: clear wins everywhere; CHECK aborts early on the first occupied cell
  always_comb
    state_n = sp.clear ? IDLE :
              state == IDLE  ? (sp.place && in_bounds ? CHECK : IDLE) :
              state == CHECK ? (occ ? IDLE : last ? WRITE : CHECK) :
              state == WRITE ? (last ? (idx == 4'd9 ? DONE : IDLE) : WRITE) : DONE;
  // status outputs decoded from state
  always_comb begin
    sp.busy = state == CHECK || state == WRITE;
    sp.all_placed = state == DONE;
  end
  // store, fleet progress, candidate latch, cell counter and result pulses
  always_ff @(posedge clk)
    if (rst || sp.clear) begin
      store <= '0;
      idx <= '0;
      ori <= 1'b0;
      lo <= 1'b0;
      lx <= '0;
      ly <= '0;
      k <= '0;
      ok <= 1'b0;
      err <= 1'b0;
    end else begin
      ok <= state == WRITE && last;
      err <= (state == IDLE && sp.place && !in_bounds) || (state == CHECK && occ);
      if (state == IDLE && sp.rotate) ori <= ~ori;
      if (state == IDLE && sp.place && in_bounds) begin
        lx <= sp.cursor_x;
        ly <= sp.cursor_y;
        lo <= ori;
        k <= '0;
      end
      if (state == CHECK) k <= last || occ ? 2'd0 : k + 2'd1;
      if (state == WRITE) begin
        store[caddr] <= 1'b1;
        k <= last ? 2'd0 : k + 2'd1;
        if (last) idx <= idx + 4'd1;
      end
    end
  // registered read port, addresses past the grid read as empty
  always_ff @(posedge clk)
    if (rst) begin
      sp.rd_ship <= 1'b0;
      sp.rd_preview <= 1'b0;
    end else begin
      sp.rd_ship <= sp.rd_addr < 7'd100 && store[sp.rd_addr];
      sp.rd_preview <= sp.rd_addr < 7'd100 && state != DONE && hit;
    end
endmodule

// File: tb/tb_ship_placement_ctrl.sv
// tb_ship_placement_ctrl: directed placement scenarios with a pulse scoreboard checked by a separate monitor
module tb_ship_placement_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ship_placement_if sp();
  ship_placement_ctrl dut (.clk(clk), .rst(rst), .sp(sp));
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int total = 0;
  int passed = 0;
  typedef struct {bit kind; int at;} exp_t;
  exp_t q[$];
  int lens[10] = '{4, 3, 3, 2, 2, 2, 1, 1, 1, 1};

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // monitor: every place_ok/place_err pulse must match the next queued expectation
  always @(negedge clk)
    if (!rst && (sp.place_ok || sp.place_err)) begin
      exp_t e;
      chk("pulse_exclusive", int'(sp.place_ok & sp.place_err), 0);
      if (q.size() == 0) chk("unexpected_pulse", 1, 0);
      else begin
        e = q.pop_front();
        chk("pulse_kind_err", int'(sp.place_err), int'(e.kind));
        chk("pulse_cycle", cyc, e.at);
      end
    end

  task automatic issue(int x, int y, bit kind, int lat, bit expect_pulse);
    sp.cursor_x = 4'(x);
    sp.cursor_y = 4'(y);
    sp.place = 1'b1;
    if (expect_pulse) q.push_back('{kind, cyc + 1 + lat});
    @(posedge clk);
    @(negedge clk);
    sp.place = 1'b0;
  endtask

  task automatic place_wait(int x, int y, bit kind, int lat);
    issue(x, y, kind, lat, 1'b1);
    repeat (lat + 1) @(negedge clk);
  endtask

  task automatic rot();
    sp.rotate = 1'b1;
    @(negedge clk);
    sp.rotate = 1'b0;
  endtask

  task automatic rd(int a, output logic s, output logic p);
    sp.rd_addr = 7'(a);
    @(negedge clk);
    s = sp.rd_ship;
    p = sp.rd_preview;
  endtask

  task automatic count_cells(output int n);
    logic s, p;
    n = 0;
    for (int a = 0; a < 100; a++) begin
      rd(a, s, p);
      n += int'(s);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic s, p;
    int n, bad, ones;
    sp.cursor_x = '0; sp.cursor_y = '0; sp.rotate = 0; sp.place = 0; sp.clear = 0; sp.rd_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", sp.busy, 0);
    chk("rst_ok", sp.place_ok, 0);
    chk("rst_err", sp.place_err, 0);
    chk("rst_idx", sp.ship_idx, 0);
    chk("rst_len", sp.ship_len, 4);
    chk("rst_orient", sp.orient, 0);
    chk("rst_all_placed", sp.all_placed, 0);
    chk("rst_rd_ship", sp.rd_ship, 0);
    // first ship, len 4 horizontal at origin
    issue(0, 0, 0, 8, 1'b1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (sp.busy) n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, 8);
    for (int a = 0; a < 5; a++) begin
      rd(a, s, p);
      chk("ship0_cell", s, a < 4 ? 1 : 0);
    end
    chk("idx_after_ship0", sp.ship_idx, 1);
    chk("len_after_ship0", sp.ship_len, 3);
    // bounds failures and a vertical placement
    place_wait(8, 5, 1, 0);
    chk("idx_after_oob", sp.ship_idx, 1);
    rd(58, s, p);
    chk("cell58_untouched", s, 0);
    place_wait(12, 3, 1, 0);
    rot();
    chk("orient_rotated", sp.orient, 1);
    place_wait(8, 5, 0, 6);
    rd(58, s, p); chk("cell58", s, 1);
    rd(68, s, p); chk("cell68", s, 1);
    rd(78, s, p); chk("cell78", s, 1);
    rd(88, s, p); chk("cell88", s, 0);
    chk("idx_after_ship1", sp.ship_idx, 2);
    place_wait(0, 8, 1, 0);
    // collision at second cell of candidate
    rot();
    place_wait(7, 7, 1, 2);
    rd(77, s, p); chk("cell77_free", s, 0);
    rd(79, s, p); chk("cell79_free", s, 0);
    chk("idx_after_collision", sp.ship_idx, 2);
    count_cells(n);
    chk("cells_before_clear", n, 7);
    // clear in the middle of WRITE
    rot();
    issue(0, 2, 0, 0, 1'b0);
    repeat (4) @(negedge clk);
    chk("busy_in_write", sp.busy, 1);
    sp.clear = 1'b1;
    @(negedge clk);
    sp.clear = 1'b0;
    chk("clear_idx", sp.ship_idx, 0);
    chk("clear_orient", sp.orient, 0);
    chk("clear_busy", sp.busy, 0);
    chk("clear_len", sp.ship_len, 4);
    count_cells(n);
    chk("cells_after_clear", n, 0);
    // preview sweep, cursor (3,2) vertical len 4
    rot();
    sp.cursor_x = 4'd3;
    sp.cursor_y = 4'd2;
    bad = 0;
    ones = 0;
    for (int a = 0; a < 128; a++) begin
      rd(a, s, p);
      ones += int'(p);
      if (p != (a == 23 || a == 33 || a == 43 || a == 53)) bad++;
      if (s) bad++;
    end
    chk("preview_sweep_bad", bad, 0);
    chk("preview_ones", ones, 4);
    rd(23, s, p);
    sp.rd_addr = 7'd24;
    #1;
    chk("preview_lag_hold", sp.rd_preview, 1);
    @(negedge clk);
    chk("preview_lag_next", sp.rd_preview, 0);
    // full legal fleet, one ship per row
    rot();
    for (int i = 0; i < 10; i++) place_wait(0, i, 0, 2 * lens[i]);
    count_cells(n);
    chk("fleet_cells", n, 20);
    chk("all_placed", sp.all_placed, 1);
    chk("done_len", sp.ship_len, 0);
    chk("done_idx", sp.ship_idx, 10);
    chk("done_busy", sp.busy, 0);
    issue(5, 5, 0, 0, 1'b0);
    repeat (10) @(negedge clk);
    rot();
    chk("done_rotate_ignored", sp.orient, 0);
    sp.cursor_x = 4'd0;
    sp.cursor_y = 4'd0;
    rd(0, s, p);
    chk("done_preview", p, 0);
    chk("done_cell0", s, 1);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ship_placement_ctrl.md
# ship_placement_ctrl

Sequences the placement phase of one player's 10x10 board. It accepts cursor position, rotate and place commands, bounds- and overlap-checks each candidate ship cell by cell, and commits it into a 100-cell occupancy store. The same store is served through a registered read port to the board draw path, together with a preview bit showing the candidate ship at the cursor. The fixed fleet is 10 ships of lengths 4,3,3,2,2,2,1,1,1,1.

## Interface
Parameters:
- none (fleet table and grid size 10x10 fixed)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- cursor_x  in  4  cursor column 0..9; values 10..15 treated as out of bounds
- cursor_y  in  4  cursor row 0..9; same rule
- rotate  in  1  one-cycle pulse, toggles orientation
- place  in  1  one-cycle pulse, request placement of current ship at cursor
- clear  in  1  one-cycle pulse, wipe board and restart fleet
- rd_addr  in  7  cell address from draw path, addr = 10*row + col
- rd_ship  out  1  occupancy of rd_addr, registered
- rd_preview  out  1  rd_addr lies in candidate footprint, registered
- busy  out  1  FSM outside IDLE/DONE
- place_ok  out  1  one-cycle pulse, ship committed
- place_err  out  1  one-cycle pulse, placement rejected
- ship_idx  out  4  index of next ship to place, 0..10
- ship_len  out  3  length of ship ship_idx; 0 when ship_idx = 10
- orient  out  1  0 = horizontal (+x), 1 = vertical (+y)
- all_placed  out  1  high in DONE

## Operation
- Store: 100 flops, one per cell; addr = 10*y + x.
- Footprint cell k (0..len-1): horizontal (x+k, y), vertical (x, y+k).
- States: IDLE, CHECK, WRITE, DONE.
- IDLE: rotate toggles orient. place with bounds fail (x>9, y>9, or end coordinate >9) -> place_err, stay IDLE. place in bounds -> latch x, y, orient, len; k=0; go CHECK.
- CHECK: read cell k per cycle. Occupied -> place_err, go IDLE (early abort). Free and k=len-1 -> k=0, go WRITE. Otherwise k++.
- WRITE: set cell k per cycle. At k=len-1: place_ok, ship_idx++, go DONE if ship_idx becomes 10, else IDLE.
- DONE: all_placed=1; place and rotate ignored.
- place and rotate while busy are ignored and not queued. Cursor changes during CHECK/WRITE do not affect the latched candidate.
- clear in any state, including mid CHECK/WRITE: next cycle store all 0, ship_idx=0, orient=0, state IDLE, no pulse. clear beats place/rotate in the same cycle. A partially written ship is discarded.
- Preview: in IDLE/CHECK/WRITE, rd_addr is inside the footprint of the current cursor (IDLE) or latched candidate (CHECK/WRITE) for the current ship_len and orient. Out-of-grid cells are never flagged. Always 0 in DONE.
- Arithmetic: end coordinate computed 5-bit to avoid wrap; address multiply 10*y at 7 bits. rd_addr >= 100 -> rd_ship=0, rd_preview=0.

## Timing
- Reset: all outputs 0 except ship_len=4; store cleared; state IDLE.
- rd_ship/rd_preview: 1-cycle latency from rd_addr, every cycle, regardless of state. A cell written in cycle t reads 1 from cycle t+1 address presentation.
- place accepted at edge t. Bounds fail: place_err high in cycle t+1 only.
- In bounds: CHECK occupies cycles t+1..t+len, busy high from t+1. Collision at cell k: place_err in cycle t+k+2, busy low same cycle.
- Success: WRITE cycles t+len+1..t+2len. place_ok, ship_idx update and busy low in cycle t+2len+1.
- place_ok and place_err are never simultaneous.

## Test plan
- Reset, place at (0,0) horizontal -> busy for 8 cycles, place_ok, cells 0..3 read 1, ship_idx=1, ship_len=3.
- Place len-3 ship at (8,5) horizontal -> place_err one cycle later, board unchanged, ship_idx stays 1. Rotate, place -> cells 58,68,78 set.
- Place a ship crossing an existing ship at its second cell -> place_err at t+3, no cell written.
- clear asserted during WRITE of the third ship -> next cycle all 100 cells 0, ship_idx=0, orient=0, IDLE.
- Place all 10 ships legally -> 20 cells set, all_placed=1, ship_len=0. Further place gives no pulse.
- Sweep rd_addr 0..127 with cursor (3,2) vertical, len 4 -> rd_preview=1 exactly for 23,33,43,53, with 1-cycle lag. Addresses >=100 read 0.
